pulse_train_generator: RTL and testbench

- Transmit-side counterpart of the team's reciprocal frequency counter.
- Generates a digital square wave of programmable period (in clk cycles) on a single output line.
- Runs either as a burst of Ncycles periods or continuously.
- Sits in the PL next to the counter. Its dataout can be looped into the counter's datain as a self-test stimulus, or driven to a pin as a reference signal.

---
 rtl/pulse_train_pkg.sv | 13 +
 rtl/pulse_train_phase_counter.sv | 28 ++
 rtl/pulse_train_generator.sv | 147 ++++++++++++++
 tb/tb_pulse_train_generator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the pulse train generator and its phase counter.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DEFAULT_COUNT_WIDTH = 32;
  localparam int DEFAULT_MIN_PERIOD  = 2;

endpackage

// File: rtl/pulse_train_phase_counter.sv
// Loadable down-counter tracking the cycles left in the current output phase.
// zero flags the last cycle of the phase.
module pulse_train_phase_counter
  import pulse_train_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   dec,
  output logic                   zero
);

  logic [COUNT_WIDTH-1:0] ph;

  // Load takes priority over decrement; the count is pure data and needs no reset
  always_ff @(posedge clk) begin
    if (load) begin
      ph <= load_val;
    end else if (dec) begin
      ph <= ph - COUNT_WIDTH'(1);
    end
  end

  assign zero = (ph == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable square-wave generator: bursts of Ncycles periods, or continuous
// when Ncycles is 0. Optional macro PULSE_TRAIN_GENERATOR_DUTY_EN adds a
// high_len input that sets the high-phase length instead of a near-50% split.
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int MIN_PERIOD  = DEFAULT_MIN_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] period,
  input  logic [COUNT_WIDTH-1:0] Ncycles,
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
  input  logic [COUNT_WIDTH-1:0] high_len,
`endif
  output logic                   dataout,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] cycles_done
);

  // Periods below MIN_PERIOD cannot hold both a high and a low cycle
  function automatic logic [COUNT_WIDTH-1:0] clamp_period(input logic [COUNT_WIDTH-1:0] p);
    return (p < COUNT_WIDTH'(MIN_PERIOD)) ? COUNT_WIDTH'(MIN_PERIOD) : p;
  endfunction

`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
  // High length saturated into [1, P-1] so both phases are at least one cycle
  function automatic logic [COUNT_WIDTH-1:0] split_high(input logic [COUNT_WIDTH-1:0] p,
                                                         input logic [COUNT_WIDTH-1:0] hl);
    if (hl == '0) return COUNT_WIDTH'(1);
    if (hl >= p)  return p - COUNT_WIDTH'(1);
    return hl;
  endfunction
`else
  // Floor half keeps the extra cycle of an odd period in the low phase
  function automatic logic [COUNT_WIDTH-1:0] split_high(input logic [COUNT_WIDTH-1:0] p);
    return p >> 1;
  endfunction
`endif

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] h_q, l_q, ncyc_q;
  logic [COUNT_WIDTH-1:0] p_in, h_in, l_in, cycles_inc;
  logic [COUNT_WIDTH-1:0] load_val;
  logic                   load, dec, zero, accept, inc, done_next;

  assign p_in = clamp_period(period);
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
  assign h_in = split_high(p_in, high_len);
`else
  assign h_in = split_high(p_in);
`endif
  assign l_in       = p_in - h_in;
  assign cycles_inc = cycles_done + COUNT_WIDTH'(1);

  pulse_train_phase_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_phase (
    .clk      (clk),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  // Next-state logic: phase sequencing, burst termination and stop handling
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = '0;
    dec        = 1'b0;
    accept     = 1'b0;
    inc        = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          accept     = 1'b1;
          load       = 1'b1;
          load_val   = h_in - COUNT_WIDTH'(1);
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          load       = 1'b1;
          load_val   = l_q - COUNT_WIDTH'(1);
          state_next = LOW;
        end
      end
      LOW: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          inc = 1'b1;
          if ((ncyc_q != '0) && (cycles_inc == ncyc_q)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            load       = 1'b1;
            load_val   = h_q - COUNT_WIDTH'(1);
            state_next = HIGH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered outputs and the settings latched on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dataout     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycles_done <= '0;
      ncyc_q      <= '0;
      h_q         <= '0;
      l_q         <= '0;
    end else begin
      state   <= state_next;
      dataout <= (state_next == HIGH);
      busy    <= (state_next != IDLE);
      done    <= done_next;
      if (accept) begin
        cycles_done <= '0;
        ncyc_q      <= Ncycles;
        h_q         <= h_in;
        l_q         <= l_in;
      end else if (inc) begin
        cycles_done <= cycles_inc;
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: directed corners plus random
// runs compared cycle by cycle against an arithmetic model of the waveform.
module tb_pulse_train_generator;

  localparam int CW    = 32;
  localparam int MIN_P = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [CW-1:0] period, Ncycles;
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
  logic [CW-1:0] high_len;
`endif
  logic          dataout, busy, done;
  logic [CW-1:0] cycles_done;

  int errors = 0;
  int checks = 0;

  // Model: a run is described by the cycle index k since the accepted start
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  longint      m_k = 0, m_P = 2, m_H = 1, m_N = 0;
  logic [31:0] m_cd = '0;

  pulse_train_generator #(.COUNT_WIDTH(CW), .MIN_PERIOD(MIN_P)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .period      (period),
    .Ncycles     (Ncycles),
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
    .high_len    (high_len),
`endif
    .dataout     (dataout),
    .busy        (busy),
    .done        (done),
    .cycles_done (cycles_done)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_high(input longint p);
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
    if (high_len == 0) return 1;
    if (longint'(high_len) >= p) return p - 1;
    return longint'(high_len);
`else
    return p / 2;
`endif
  endfunction

  task automatic model_update();
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_cd     = '0;
    end else if (m_active) begin
      if (stop) begin
        m_active = 1'b0;
      end else begin
        m_k++;
        if (m_N != 0 && m_k > m_N * m_P) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_cd     = 32'(m_N);
        end else begin
          m_cd = 32'((m_k - 1) / m_P);
        end
      end
    end else if (start && !stop) begin
      m_active = 1'b1;
      m_k      = 1;
      m_P      = (period < MIN_P) ? longint'(MIN_P) : longint'(period);
      m_H      = model_high(m_P);
      m_N      = longint'(Ncycles);
      m_cd     = '0;
    end
  endtask

  task automatic step();
    logic exp_out;
    @(posedge clk);
    model_update();
    @(negedge clk);
    exp_out = m_active && (((m_k - 1) % m_P) < m_H);
    chk("dataout", {31'd0, dataout}, {31'd0, exp_out});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("cycles_done", cycles_done, m_cd);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go(input logic [CW-1:0] p, input logic [CW-1:0] n);
    period  = p;
    Ncycles = n;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    int rises;
    logic prev;
    rst = 1'b1; start = 1'b0; stop = 1'b0; period = '0; Ncycles = '0;
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
    high_len = '0;
`endif
    steps(2);
    rst = 1'b0;
    steps(2);

    // Burst period=4 x3: done on the 13th cycle after start
    go(4, 3);
    steps(11);
    step();
    chk("burst_done", {31'd0, done}, 32'd1);
    chk("burst_count", cycles_done, 32'd3);
    steps(2);

    // Odd period and clamped tiny periods
    go(5, 2); steps(11);
    go(0, 2); steps(5);
    go(1, 2); steps(5);

    // Continuous period=10: 100 rising edges in 1000 cycles
    rises = 0; prev = 1'b0;
    go(10, 0);
    if (dataout && !prev) rises++;
    prev = dataout;
    for (int i = 0; i < 999; i++) begin
      step();
      if (dataout && !prev) rises++;
      prev = dataout;
    end
    chk("cont_rises", 32'(rises), 32'd100);
    step();
    chk("cont_count", cycles_done, 32'd100);
    stop = 1'b1; step(); stop = 1'b0;
    steps(2);

    // Stop during the second high phase of period=8 x5
    go(8, 5); steps(9);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_out", {31'd0, dataout}, 32'd0);
    chk("stop_count", cycles_done, 32'd1);
    steps(3);

    // Reset at the same point
    go(8, 5); steps(9);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", cycles_done, 32'd0);
    steps(2);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; period = 4; Ncycles = 1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {31'd0, busy}, 32'd0);
    steps(2);

    // Back-to-back: start sampled in the done cycle
    go(2, 2); steps(3);
    step();
    chk("b2b_done", {31'd0, done}, 32'd1);
    period = 3; Ncycles = 1; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_rise", {31'd0, dataout}, 32'd1);
    steps(4);

    // Start and setting changes while busy are ignored
    go(6, 2); steps(2);
    period = 3; Ncycles = 9; start = 1'b1;
    steps(3);
    start = 1'b0;
    steps(10);

`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
    // Duty control: high_len 3, 0 and 12 over period 10
    high_len = 3;  go(10, 1); steps(10);
    high_len = 0;  go(10, 1); steps(10);
    high_len = 12; go(10, 1); steps(10);
    high_len = 0;
`endif

    // Random runs with random start/stop/reset traffic
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 40; c++) begin
        period  = $urandom_range(0, 12);
        Ncycles = $urandom_range(0, 4);
`ifdef PULSE_TRAIN_GENERATOR_DUTY_EN
        high_len = $urandom_range(0, 13);
`endif
        start = ($urandom_range(0, 3) == 0);
        stop  = ($urandom_range(0, 19) == 0);
        rst   = ($urandom_range(0, 59) == 0);
        step();
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    steps(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
